// File: rtl/sat_compute_pipe_if.sv
// Request/response bundle for sat_compute_pipe: valid/ready request side plus registered result side.
// With CU_FLAGS_EN defined the bundle also carries the {N,Z,V} flags output.
interface sat_compute_pipe_if #(parameter int DATA_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              ovfl;
`ifdef CU_FLAGS_EN
  logic [2:0]        flags;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, ovfl
`ifdef CU_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, ovfl
`ifdef CU_FLAGS_EN
    , output flags
`endif
  );
endinterface

// File: rtl/sat_compute_pipe.sv
// Registered saturating ALU: ADD/SUB/PADD/shifts in one cycle, RED over N lane cycles, full backpressure.
// Optional macro CU_FLAGS_EN adds the {N,Z,V} flags output.

// One signed lane of the packed add, saturating to its own min/max.
module sat_lane_add #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  logic [W-1:0] s;
  assign s   = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  assign y   = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s;
endmodule

module sat_compute_pipe #(
  parameter int DATA_W  = 16,
  parameter int LANE_W  = 4,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  sat_compute_pipe_if.slave  bus
);
  localparam int N     = DATA_W / LANE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_PADD = 3'b010;
  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_RED  = 3'b110;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] acc;
  logic [N-1:0][LANE_W-1:0] ra_q, rb_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] result_q;
  logic              ovfl_q;

  logic accept;
  assign bus.in_ready  = (state == S_IDLE) & (~out_valid_q | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovfl      = ovfl_q;

  // Full-width saturating add/sub: overflow saturates toward the sign of a.
  logic [DATA_W-1:0] sum, dif;
  logic              sum_ovf, dif_ovf;
  assign sum     = bus.a + bus.b;
  assign dif     = bus.a - bus.b;
  assign sum_ovf = (bus.a[DATA_W-1] == bus.b[DATA_W-1]) && (sum[DATA_W-1] != bus.a[DATA_W-1]);
  assign dif_ovf = (bus.a[DATA_W-1] != bus.b[DATA_W-1]) && (dif[DATA_W-1] != bus.a[DATA_W-1]);

  // Per-lane packed add.
  logic [N-1:0][LANE_W-1:0] a_ln, b_ln, p_ln;
  logic [N-1:0]             p_ovf;
  assign a_ln = bus.a;
  assign b_ln = bus.b;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sat_lane_add #(.W(LANE_W)) u_lane (
      .a   (a_ln[i]),
      .b   (b_ln[i]),
      .y   (p_ln[i]),
      .ovf (p_ovf[i])
    );
  end

  // Shifts; rotate uses a complementary left shift, which yields 0 when the amount is 0.
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W:0]   lsh;
  logic [DATA_W-1:0]  sll_v, sra_v, ror_v;
  assign shamt = bus.b[SHAMT_W-1:0];
  assign lsh   = (SHAMT_W+1)'(DATA_W) - {1'b0, shamt};
  assign sll_v = bus.a << shamt;
  assign sra_v = DATA_W'($signed(bus.a) >>> shamt);
  assign ror_v = (bus.a >> shamt) | (bus.a << lsh);

  logic [DATA_W-1:0] single_res;
  logic              single_ovf;
  logic              single_arith;
  always_comb begin
    single_res   = '0;
    single_ovf   = 1'b0;
    single_arith = 1'b0;
    case (bus.op)
      OP_ADD: begin
        single_res   = sum_ovf ? (bus.a[DATA_W-1] ? MIN_V : MAX_V) : sum;
        single_ovf   = sum_ovf;
        single_arith = 1'b1;
      end
      OP_SUB: begin
        single_res   = dif_ovf ? (bus.a[DATA_W-1] ? MIN_V : MAX_V) : dif;
        single_ovf   = dif_ovf;
        single_arith = 1'b1;
      end
      OP_PADD: begin
        single_res   = p_ln;
        single_ovf   = |p_ovf;
        single_arith = 1'b1;
      end
      OP_SLL:  single_res = sll_v;
      OP_SRA:  single_res = sra_v;
      OP_ROR:  single_res = ror_v;
      default: single_res = '0;
    endcase
  end

  // Reduction step: both lanes are sign-extended before accumulation; the sum wraps.
  logic [DATA_W-1:0] ext_a, ext_b, acc_next;
  logic              last_lane;
  assign ext_a     = DATA_W'($signed(ra_q[idx]));
  assign ext_b     = DATA_W'($signed(rb_q[idx]));
  assign acc_next  = acc + ext_a + ext_b;
  assign last_lane = (idx == IDX_W'(N-1));

`ifdef CU_FLAGS_EN
  logic [2:0] flags_q;
  assign bus.flags = flags_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      acc         <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovfl_q      <= 1'b0;
`ifdef CU_FLAGS_EN
      flags_q     <= 3'b000;
`endif
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.op == OP_RED) begin
              ra_q  <= a_ln;
              rb_q  <= b_ln;
              acc   <= '0;
              idx   <= '0;
              state <= S_ACC;
            end else begin
              result_q    <= single_res;
              ovfl_q      <= single_ovf;
              out_valid_q <= 1'b1;
`ifdef CU_FLAGS_EN
              if (single_arith)
                flags_q <= {single_res[DATA_W-1], single_res == '0, single_ovf};
`endif
            end
          end
        end
        default: begin
          acc <= acc_next;
          if (!last_lane)
            idx <= idx + IDX_W'(1);
          if (last_lane) begin
            result_q    <= acc_next;
            ovfl_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
`ifdef CU_FLAGS_EN
            flags_q     <= {acc_next[DATA_W-1], acc_next == '0, 1'b0};
`endif
          end
        end
      endcase
    end
  end

`ifndef CU_FLAGS_EN
  logic unused_arith;
  assign unused_arith = single_arith;
`endif
endmodule
